mem_wb_data_access_unit: RTL and testbench

- Consumer end of the EX/MEM data path. Takes the two EX/MEM data bytes (top/bot) plus an operation code from the memory stage.
- Either passes the bytes straight through to writeback, or runs byte-wide data-memory transactions with a req/ack handshake.
- Returns writeback bytes (top/bot) for the register file.
- Stalls the pipeline while a memory access is outstanding. A watchdog aborts accesses that are never acknowledged.

---
 rtl/mem_wb_data_access_unit.sv | 215 +++++++++++++++++++++
 tb/tb_mem_wb_data_access_unit.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_data_access_unit.sv
// mem_wb_data_access_unit
//   Consumer end of the EX/MEM data path. Pass ops go straight to writeback
//   one cycle later; load byte / store byte / load pair run byte-wide
//   req/ack transactions against data memory while stalling the pipeline.
//   A watchdog aborts accesses that never see mem_ack and sets a sticky
//   mem_err flag.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   ex_valid/ex_op        EX/MEM entry valid, op (00 pass, 01 ldb, 10 stb, 11 ldp)
//   ex_data_top/bot       pass: writeback bytes; memory ops: address[15:8]/[7:0]
//   ex_store_data         store byte
//   stall                 high while an access is in flight
//   mem_req/we/addr/wdata memory request channel, held stable until mem_ack
//   mem_rdata/mem_ack     memory response, rdata sampled with ack
//   wb_valid/wb_data_*    one-cycle writeback pulse and its bytes (held after)
//   mem_err               sticky watchdog-abort flag
module mem_wb_data_access_unit #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TIMEOUT_W      = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ex_valid,
   input  logic [1:0]  ex_op,
   input  logic [7:0]  ex_data_top,
   input  logic [7:0]  ex_data_bot,
   input  logic [7:0]  ex_store_data,
   output logic        stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ack,
   output logic        wb_valid,
   output logic [7:0]  wb_data_top,
   output logic [7:0]  wb_data_bot,
   output logic        mem_err
);

   localparam logic [1:0] OP_PASS = 2'b00;
   localparam logic [1:0] OP_LDB  = 2'b01;
   localparam logic [1:0] OP_STB  = 2'b10;
   localparam logic [1:0] OP_LDP  = 2'b11;

   // The watchdog fires on the edge that would take the count to
   // TIMEOUT_CYCLES, so the request is high for exactly TIMEOUT_CYCLES cycles.
   localparam bit                   WDOG_EN   = (TIMEOUT_CYCLES != 0);
   localparam int                   LAST_I    = WDOG_EN ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic [TIMEOUT_W-1:0] WDOG_LAST = TIMEOUT_W'(LAST_I);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_GAP = 2'd2} state_e;

   state_e               state_q, state_d;
   logic [1:0]           op_q, op_d;
   logic                 beat_q, beat_d;        // 1 = second beat of a load pair
   logic [7:0]           lo_q, lo_d;            // load pair low byte, kept until wb
   logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
   logic                 stall_q, stall_d;
   logic                 mem_req_q, mem_req_d;
   logic                 mem_we_q, mem_we_d;
   logic [15:0]          mem_addr_q, mem_addr_d;
   logic [7:0]           mem_wdata_q, mem_wdata_d;
   logic                 wb_valid_q, wb_valid_d;
   logic [7:0]           wb_top_q, wb_top_d;
   logic [7:0]           wb_bot_q, wb_bot_d;
   logic                 mem_err_q, mem_err_d;

   logic accept, ack_hit, wdog_hit;

   always_comb begin
      accept   = (state_q == S_IDLE) && ex_valid;
      // mem_req is high exactly in ACCESS, so acks outside it are ignored.
      ack_hit  = (state_q == S_ACCESS) && mem_ack;
      // Ack on the last allowed cycle wins over the timeout.
      wdog_hit = WDOG_EN && (state_q == S_ACCESS) && !mem_ack && (wdog_q == WDOG_LAST);
   end

   // State register
   always_ff @(posedge clock) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept && ex_op != OP_PASS) state_d = S_ACCESS;
         end
         S_ACCESS: begin
            if (ack_hit)       state_d = (op_q == OP_LDP && !beat_q) ? S_GAP : S_IDLE;
            else if (wdog_hit) state_d = S_IDLE;
         end
         S_GAP:   state_d = S_ACCESS;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs and datapath (all registered)
   always_comb begin
      op_d        = op_q;
      beat_d      = beat_q;
      lo_d        = lo_q;
      wdog_d      = wdog_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      wb_valid_d  = 1'b0;
      wb_top_d    = wb_top_q;
      wb_bot_d    = wb_bot_q;
      mem_err_d   = mem_err_q;
      mem_req_d   = (state_d == S_ACCESS);
      stall_d     = (state_d != S_IDLE);

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (ex_op == OP_PASS) begin
                  wb_valid_d = 1'b1;
                  wb_top_d   = ex_data_top;
                  wb_bot_d   = ex_data_bot;
               end else begin
                  op_d        = ex_op;
                  beat_d      = 1'b0;
                  lo_d        = 8'h00;
                  wdog_d      = '0;
                  mem_we_d    = (ex_op == OP_STB);
                  mem_addr_d  = {ex_data_top, ex_data_bot};
                  mem_wdata_d = ex_store_data;
               end
            end
         end
         S_ACCESS: begin
            if (ack_hit) begin
               if (op_q == OP_LDB) begin
                  wb_valid_d = 1'b1;
                  wb_top_d   = 8'h00;
                  wb_bot_d   = mem_rdata;
               end else if (op_q == OP_LDP) begin
                  if (!beat_q) begin
                     lo_d   = mem_rdata;
                     beat_d = 1'b1;
                  end else begin
                     wb_valid_d = 1'b1;
                     wb_top_d   = mem_rdata;
                     wb_bot_d   = lo_q;
                  end
               end
            end else if (wdog_hit) begin
               mem_err_d = 1'b1;
               // Loads still complete; bytes never returned read as zero.
               if (op_q != OP_STB) begin
                  wb_valid_d = 1'b1;
                  wb_top_d   = 8'h00;
                  wb_bot_d   = (op_q == OP_LDP && beat_q) ? lo_q : 8'h00;
               end
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         S_GAP: begin
            // Second beat of the pair; 16-bit wrap is intended.
            mem_addr_d = mem_addr_q + 16'd1;
            wdog_d     = '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         op_q        <= '0;
         beat_q      <= 1'b0;
         lo_q        <= '0;
         wdog_q      <= '0;
         stall_q     <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         wb_valid_q  <= 1'b0;
         wb_top_q    <= '0;
         wb_bot_q    <= '0;
         mem_err_q   <= 1'b0;
      end else begin
         op_q        <= op_d;
         beat_q      <= beat_d;
         lo_q        <= lo_d;
         wdog_q      <= wdog_d;
         stall_q     <= stall_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         wb_valid_q  <= wb_valid_d;
         wb_top_q    <= wb_top_d;
         wb_bot_q    <= wb_bot_d;
         mem_err_q   <= mem_err_d;
      end
   end

   assign stall       = stall_q;
   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign wb_valid    = wb_valid_q;
   assign wb_data_top = wb_top_q;
   assign wb_data_bot = wb_bot_q;
   assign mem_err     = mem_err_q;

endmodule

// File: tb/tb_mem_wb_data_access_unit.sv
// Testbench for mem_wb_data_access_unit: directed scenarios plus randomized
// transactions checked against a transaction-level model of the unit.
module tb_mem_wb_data_access_unit;

   localparam int TO = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        ex_valid;
   logic [1:0]  ex_op;
   logic [7:0]  ex_data_top, ex_data_bot, ex_store_data;
   logic        stall, mem_req, mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata;
   logic        mem_ack;
   logic        wb_valid;
   logic [7:0]  wb_data_top, wb_data_bot;
   logic        mem_err;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] mem [logic [15:0]];

   mem_wb_data_access_unit #(.TIMEOUT_CYCLES(TO), .TIMEOUT_W(3)) dut (
      .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_op(ex_op),
      .ex_data_top(ex_data_top), .ex_data_bot(ex_data_bot), .ex_store_data(ex_store_data),
      .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .wb_valid(wb_valid), .wb_data_top(wb_data_top), .wb_data_bot(wb_data_bot),
      .mem_err(mem_err)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL global_time_limit: simulation did not finish, required finish");
      $fatal(1);
   end

   // Backing memory: written bytes, otherwise an address-derived pattern.
   function automatic logic [7:0] mem_rd(input logic [15:0] a);
      logic [7:0] r;
      if (mem.exists(a)) return mem[a];
      r = a[7:0] * 8'd7 + a[15:8] + 8'h3C;
      return r;
   endfunction

   task automatic do_reset;
      reset = 1'b1; ex_valid = 1'b0; mem_ack = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_reset;
      do_reset;
      n_checks++;
      if ({stall, mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_data_top, wb_data_bot, mem_err} !== 45'd0) begin
         n_fail++;
         $display("FAIL reset_state: got %h required 0",
                  {stall, mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_data_top, wb_data_bot, mem_err});
      end
   endtask

   task automatic test_pass_stream;
      logic [15:0] pairs [3];
      int stall_seen;
      pairs[0] = 16'h1234; pairs[1] = 16'h5678; pairs[2] = 16'h9ABC;
      stall_seen = 0;
      for (int i = 0; i <= 3; i++) begin
         if (i > 0) begin
            n_checks++;
            if (wb_valid !== 1'b1 || {wb_data_top, wb_data_bot} !== pairs[i-1]) begin
               n_fail++;
               $display("FAIL pass_stream_%0d: got v=%b wb=%h required v=1 wb=%h",
                        i-1, wb_valid, {wb_data_top, wb_data_bot}, pairs[i-1]);
            end
         end
         if (stall) stall_seen++;
         if (i < 3) begin
            ex_valid = 1'b1; ex_op = 2'b00;
            ex_data_top = pairs[i][15:8]; ex_data_bot = pairs[i][7:0];
         end else begin
            ex_valid = 1'b0;
         end
         @(negedge clock);
      end
      n_checks++;
      if (wb_valid !== 1'b0) begin
         n_fail++; $display("FAIL pass_stream_end: wb_valid=%b required 0", wb_valid);
      end
      if (stall) stall_seen++;
      n_checks++;
      if (stall_seen != 0) begin
         n_fail++; $display("FAIL pass_stream_stall: stall cycles=%0d required 0", stall_seen);
      end
   endtask

   task automatic test_load_byte;
      int reqs, stalls, pulses, bad;
      logic [15:0] wb;
      reqs = 0; stalls = 0; pulses = 0; bad = 0; wb = 16'h0;
      ex_valid = 1'b1; ex_op = 2'b01; ex_data_top = 8'h12; ex_data_bot = 8'h34;
      @(negedge clock);
      ex_valid = 1'b0; ex_data_top = 8'hEE; ex_data_bot = 8'hDD;
      for (int c = 0; c < 10; c++) begin
         if (mem_req) begin
            reqs++;
            if (mem_addr !== 16'h1234 || mem_we !== 1'b0) bad++;
            if (reqs == 4) begin mem_ack = 1'b1; mem_rdata = 8'hA5; end
         end
         if (stall) stalls++;
         if (wb_valid) begin pulses++; wb = {wb_data_top, wb_data_bot}; end
         @(negedge clock);
         mem_ack = 1'b0; mem_rdata = 8'h00;
      end
      n_checks++;
      if (reqs != 4) begin n_fail++; $display("FAIL ldb_req_cycles: got %0d required 4", reqs); end
      n_checks++;
      if (stalls != 4) begin n_fail++; $display("FAIL ldb_stall_cycles: got %0d required 4", stalls); end
      n_checks++;
      if (pulses != 1) begin n_fail++; $display("FAIL ldb_pulses: got %0d required 1", pulses); end
      n_checks++;
      if (wb !== 16'h00A5) begin n_fail++; $display("FAIL ldb_data: got %h required 00a5", wb); end
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL ldb_addr_we: %0d bad cycles required 0", bad); end
   endtask

   task automatic test_load_pair;
      int beats, wb_at;
      logic prev;
      logic [4:0] pat;
      logic [15:0] baddr [2];
      logic [15:0] wb;
      beats = 0; wb_at = -1; prev = 1'b0; pat = 5'd0; wb = 16'h0;
      baddr[0] = 16'h1111; baddr[1] = 16'h1111;
      ex_valid = 1'b1; ex_op = 2'b11; ex_data_top = 8'hFF; ex_data_bot = 8'hFF;
      @(negedge clock);
      ex_valid = 1'b0; ex_data_top = 8'h00; ex_data_bot = 8'h00;
      for (int c = 1; c <= 8; c++) begin
         if (c <= 5) pat = {pat[3:0], mem_req};
         if (mem_req) begin
            if (!prev) begin
               if (beats < 2) baddr[beats] = mem_addr;
               beats++;
            end
            mem_ack = 1'b1;
            mem_rdata = (beats == 1) ? 8'h11 : 8'h22;
         end
         if (wb_valid && wb_at < 0) begin wb_at = c; wb = {wb_data_top, wb_data_bot}; end
         prev = mem_req;
         @(negedge clock);
         mem_ack = 1'b0;
      end
      n_checks++;
      if (beats != 2) begin n_fail++; $display("FAIL ldp_beats: got %0d required 2", beats); end
      n_checks++;
      if (baddr[0] !== 16'hFFFF || baddr[1] !== 16'h0000) begin
         n_fail++; $display("FAIL ldp_addrs: got %h,%h required ffff,0000", baddr[0], baddr[1]);
      end
      n_checks++;
      if (pat !== 5'b10100) begin n_fail++; $display("FAIL ldp_req_gap: req trace %b required 10100", pat); end
      n_checks++;
      if (wb !== 16'h2211) begin n_fail++; $display("FAIL ldp_data: got %h required 2211", wb); end
      n_checks++;
      if (wb_at != 4) begin n_fail++; $display("FAIL ldp_latency: wb_valid at cycle %0d required 4", wb_at); end
   endtask

   task automatic test_store;
      int reqs, stalls, pulses, bad;
      reqs = 0; stalls = 0; pulses = 0; bad = 0;
      ex_valid = 1'b1; ex_op = 2'b10; ex_data_top = 8'h00; ex_data_bot = 8'h40; ex_store_data = 8'h5A;
      @(negedge clock);
      ex_valid = 1'b0; ex_store_data = 8'h00;
      for (int c = 0; c < 8; c++) begin
         if (mem_req) begin
            reqs++;
            if (mem_addr !== 16'h0040 || mem_we !== 1'b1 || mem_wdata !== 8'h5A) bad++;
            if (reqs == 2) mem_ack = 1'b1;
         end
         if (stall) stalls++;
         if (wb_valid) pulses++;
         @(negedge clock);
         mem_ack = 1'b0;
      end
      n_checks++;
      if (reqs != 2 || stalls != 2) begin
         n_fail++; $display("FAIL stb_cycles: req=%0d stall=%0d required 2,2", reqs, stalls);
      end
      n_checks++;
      if (pulses != 0) begin n_fail++; $display("FAIL stb_no_wb: pulses=%0d required 0", pulses); end
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL stb_req_fields: %0d bad cycles required 0", bad); end
      // Previous writeback was the load pair {22,11}; a store must not disturb it.
      n_checks++;
      if ({wb_data_top, wb_data_bot} !== 16'h2211) begin
         n_fail++; $display("FAIL stb_wb_hold: got %h required 2211", {wb_data_top, wb_data_bot});
      end
   endtask

   // ack_at = 0 means no ack at all; otherwise ack in that request cycle.
   task automatic run_ldb_timeout(input int ack_at, input logic [15:0] a, input logic exp_err,
                                  input logic [15:0] exp_wb);
      int reqs, pulses;
      logic [15:0] wb;
      reqs = 0; pulses = 0; wb = 16'hDEAD;
      ex_valid = 1'b1; ex_op = 2'b01; ex_data_top = a[15:8]; ex_data_bot = a[7:0];
      @(negedge clock);
      ex_valid = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (mem_req) begin
            reqs++;
            if (reqs == ack_at) begin mem_ack = 1'b1; mem_rdata = 8'h3C; end
         end
         if (wb_valid) begin pulses++; wb = {wb_data_top, wb_data_bot}; end
         @(negedge clock);
         mem_ack = 1'b0;
      end
      n_checks++;
      if (reqs != TO) begin n_fail++; $display("FAIL wdog_req_cycles(ack_at=%0d): got %0d required %0d", ack_at, reqs, TO); end
      n_checks++;
      if (mem_err !== exp_err) begin n_fail++; $display("FAIL wdog_err(ack_at=%0d): got %b required %b", ack_at, mem_err, exp_err); end
      n_checks++;
      if (pulses != 1 || wb !== exp_wb) begin
         n_fail++; $display("FAIL wdog_wb(ack_at=%0d): pulses=%0d wb=%h required 1 %h", ack_at, pulses, wb, exp_wb);
      end
   endtask

   task automatic test_timeout;
      run_ldb_timeout(0, 16'h0300, 1'b1, 16'h0000);
      // mem_err must survive an unrelated later operation.
      ex_valid = 1'b1; ex_op = 2'b00; ex_data_top = 8'h77; ex_data_bot = 8'h88;
      @(negedge clock);
      ex_valid = 1'b0;
      n_checks++;
      if (wb_valid !== 1'b1 || {wb_data_top, wb_data_bot} !== 16'h7788 || mem_err !== 1'b1) begin
         n_fail++; $display("FAIL wdog_sticky: v=%b wb=%h err=%b required 1 7788 1",
                            wb_valid, {wb_data_top, wb_data_bot}, mem_err);
      end
      @(negedge clock);
      do_reset;
      run_ldb_timeout(TO, 16'h0301, 1'b0, 16'h003C);
   endtask

   task automatic test_reset_mid_access;
      int pulses;
      pulses = 0;
      ex_valid = 1'b1; ex_op = 2'b11; ex_data_top = 8'h10; ex_data_bot = 8'h00;
      @(negedge clock);
      ex_valid = 1'b0;
      mem_ack = 1'b1; mem_rdata = 8'h44;
      @(negedge clock);
      mem_ack = 1'b0;
      @(negedge clock);
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== 16'h1001) begin
         n_fail++; $display("FAIL rst_mid_beat2: req=%b addr=%h required 1 1001", mem_req, mem_addr);
      end
      reset = 1'b1;
      @(negedge clock);
      n_checks++;
      if (mem_req !== 1'b0 || stall !== 1'b0 || wb_valid !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid_outputs: req=%b stall=%b wbv=%b required 0 0 0", mem_req, stall, wb_valid);
      end
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (wb_valid || mem_req) pulses++;
         mem_ack = 1'b1;
         @(negedge clock);
         mem_ack = 1'b0;
      end
      n_checks++;
      if (pulses != 0) begin n_fail++; $display("FAIL rst_mid_spurious: %0d active cycles required 0", pulses); end
      ex_valid = 1'b1; ex_op = 2'b00; ex_data_top = 8'hAB; ex_data_bot = 8'hCD;
      @(negedge clock);
      ex_valid = 1'b0;
      n_checks++;
      if (wb_valid !== 1'b1 || {wb_data_top, wb_data_bot} !== 16'hABCD) begin
         n_fail++; $display("FAIL rst_mid_pass: v=%b wb=%h required 1 abcd", wb_valid, {wb_data_top, wb_data_bot});
      end
      @(negedge clock);
   endtask

   task automatic test_random;
      logic        err_exp;
      logic [15:0] wb_exp;
      logic [1:0]  op;
      logic [15:0] a;
      logic [7:0]  sd;
      int          lat [2];
      logic        exp_v;
      logic [15:0] exp_wb;
      int          exp_beats, exp_reqs;
      int          beats, wcnt, reqs, pulses, bad, cyc;
      logic        prev, done;
      do_reset;
      err_exp = 1'b0; wb_exp = 16'h0000;
      for (int t = 0; t < 60; t++) begin
         op = 2'($urandom_range(0, 3)); a = 16'($urandom); sd = 8'($urandom);
         lat[0] = int'($urandom_range(0, 5)); lat[1] = int'($urandom_range(0, 5));
         // Transaction-level expectation; lat >= TO means memory never answers.
         exp_v = 1'b0; exp_wb = wb_exp; exp_beats = 0; exp_reqs = 0;
         case (op)
            2'b00: begin exp_v = 1'b1; exp_wb = a; end
            2'b01: begin
               exp_beats = 1; exp_v = 1'b1;
               exp_reqs = (lat[0] < TO) ? lat[0] + 1 : TO;
               exp_wb = {8'h00, (lat[0] < TO) ? mem_rd(a) : 8'h00};
               if (lat[0] >= TO) err_exp = 1'b1;
            end
            2'b10: begin
               exp_beats = 1;
               exp_reqs = (lat[0] < TO) ? lat[0] + 1 : TO;
               if (lat[0] >= TO) err_exp = 1'b1;
            end
            default: begin
               exp_v = 1'b1;
               if (lat[0] >= TO) begin
                  exp_beats = 1; exp_reqs = TO; exp_wb = 16'h0000; err_exp = 1'b1;
               end else begin
                  exp_beats = 2;
                  exp_reqs = lat[0] + 1 + ((lat[1] < TO) ? lat[1] + 1 : TO);
                  exp_wb = {(lat[1] < TO) ? mem_rd(a + 16'd1) : 8'h00, mem_rd(a)};
                  if (lat[1] >= TO) err_exp = 1'b1;
               end
            end
         endcase

         ex_valid = 1'b1; ex_op = op; ex_data_top = a[15:8]; ex_data_bot = a[7:0]; ex_store_data = sd;
         @(negedge clock);
         ex_valid = 1'b0; ex_data_top = 8'($urandom); ex_data_bot = 8'($urandom); ex_store_data = 8'($urandom);
         beats = 0; wcnt = 0; reqs = 0; pulses = 0; bad = 0; cyc = 0; prev = 1'b0; done = 1'b0;
         while (!done && cyc < 30) begin
            if (mem_req) begin
               if (!prev) begin beats++; wcnt = 0; end
               wcnt++; reqs++;
               if (mem_addr !== ((beats == 2) ? a + 16'd1 : a) || mem_we !== (op == 2'b10) ||
                   (op == 2'b10 && mem_wdata !== sd)) bad++;
               if (wcnt == lat[(beats > 1) ? 1 : 0] + 1) begin
                  mem_ack = 1'b1; mem_rdata = mem_rd(mem_addr);
                  if (mem_we) mem[mem_addr] = mem_wdata;
               end
            end else if ($urandom_range(0, 1) == 1) begin
               // Stray ack with no request outstanding.
               mem_ack = 1'b1; mem_rdata = 8'($urandom);
            end
            if (wb_valid) pulses++;
            if (!stall) done = 1'b1;
            prev = mem_req; cyc++;
            @(negedge clock);
            mem_ack = 1'b0;
         end
         n_checks++;
         if (!done) begin n_fail++; $display("FAIL rand_%0d_hang: still stalled after %0d cycles", t, cyc); end
         n_checks++;
         if (pulses != int'(exp_v)) begin n_fail++; $display("FAIL rand_%0d_pulses: op=%0d got %0d required %0d", t, op, pulses, exp_v); end
         n_checks++;
         if ({wb_data_top, wb_data_bot} !== exp_wb) begin
            n_fail++; $display("FAIL rand_%0d_wb: op=%0d a=%h lat=%0d,%0d got %h required %h",
                               t, op, a, lat[0], lat[1], {wb_data_top, wb_data_bot}, exp_wb);
         end
         n_checks++;
         if (beats != exp_beats || reqs != exp_reqs) begin
            n_fail++; $display("FAIL rand_%0d_reqs: op=%0d beats=%0d reqs=%0d required %0d %0d",
                               t, op, beats, reqs, exp_beats, exp_reqs);
         end
         n_checks++;
         if (bad != 0) begin n_fail++; $display("FAIL rand_%0d_req_fields: %0d bad cycles required 0", t, bad); end
         n_checks++;
         if (mem_err !== err_exp) begin n_fail++; $display("FAIL rand_%0d_err: got %b required %b", t, mem_err, err_exp); end
         wb_exp = exp_wb;
      end
   endtask

   initial begin
      reset = 1'b1; ex_valid = 1'b0; ex_op = 2'b00; ex_data_top = 8'h00; ex_data_bot = 8'h00;
      ex_store_data = 8'h00; mem_rdata = 8'h00; mem_ack = 1'b0;
      test_reset;
      test_pass_stream;
      test_load_byte;
      test_load_pair;
      test_store;
      test_timeout;
      test_reset_mid_access;
      test_random;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
